// File: rtl/mux2to1_reg.sv
// mux2to1_reg: registered 2:1 selector with capture enable and async reset.
// Define MUX21_PARITY_EN to add the registered even-parity output Y_par.
module mux2to1_reg #(
   parameter int unsigned      WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   input  logic             S,
   input  logic             en,
   output logic             y_sel,
`ifdef MUX21_PARITY_EN
   output logic [WIDTH-1:0] Y,
   output logic             Y_par
`else
   output logic [WIDTH-1:0] Y
`endif
);

   logic [WIDTH-1:0] next_y;

   // ternary keeps the bitwise D1/D2 merge when S is unknown in simulation
   always_comb begin
      next_y = S ? D2 : D1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Y     <= RESET_VAL;
         y_sel <= 1'b0;
      end else if (en) begin
         Y     <= next_y;
         y_sel <= S;
      end
   end

`ifdef MUX21_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Y_par <= ^RESET_VAL;
      end else if (en) begin
         Y_par <= ^next_y;
      end
   end
`endif

endmodule

// File: tb/tb_mux2to1_reg.sv
// tb_mux2to1_reg: directed and random checks of mux2to1_reg (WIDTH=8).
// Parity checks are active when MUX21_PARITY_EN is defined.
module tb_mux2to1_reg;

   localparam int unsigned W = 8;
   localparam logic [W-1:0] RV = 8'h00;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] D1;
   logic [W-1:0] D2;
   logic         S;
   logic         en;
   logic [W-1:0] Y;
   logic         y_sel;
`ifdef MUX21_PARITY_EN
   logic         Y_par;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] m_y;
   logic         m_sel;

   mux2to1_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .D1    (D1),
      .D2    (D2),
      .S     (S),
      .en    (en),
      .y_sel (y_sel),
`ifdef MUX21_PARITY_EN
      .Y     (Y),
      .Y_par (Y_par)
`else
      .Y     (Y)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".Y"}, 64'(Y), 64'(m_y));
      chk({tag, ".y_sel"}, 64'(y_sel), 64'(m_sel));
`ifdef MUX21_PARITY_EN
      chk({tag, ".Y_par"}, 64'(Y_par), 64'(^m_y));
`endif
   endtask

   // Drive away from the edge, let one rising edge pass, then check.
   task automatic cyc(input logic [W-1:0] d1, input logic [W-1:0] d2,
                      input logic s, input logic e, input string tag);
      D1 = d1;
      D2 = d2;
      S  = s;
      en = e;
      @(posedge clk);
      if (e) begin
         m_y   = s ? d2 : d1;
         m_sel = s;
      end
      #1;
      chk_all(tag);
   endtask

   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      #2;
      m_y   = RV;
      m_sel = 1'b0;
      chk_all(tag);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      rst_n = 1'b0;
      D1 = '0;
      D2 = '0;
      S  = 1'b0;
      en = 1'b0;
      m_y   = RV;
      m_sel = 1'b0;
      #3;
      chk_all("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      cyc(8'h00, 8'h01, 1'b0, 1'b1, "t1a");
      cyc(8'h00, 8'h01, 1'b0, 1'b1, "t1b");
      cyc(8'h00, 8'h01, 1'b1, 1'b1, "t2a");
      cyc(8'h00, 8'h01, 1'b1, 1'b1, "t2b");

      cyc(8'hA5, 8'h3C, 1'b0, 1'b1, "t3a");
      chk("t3a.lit", 64'(Y), 64'hA5);
      cyc(8'hA5, 8'h3C, 1'b1, 1'b1, "t3b");
      chk("t3b.lit", 64'(Y), 64'h3C);
      cyc(8'hA5, 8'h3C, 1'b0, 1'b1, "t3c");
      cyc(8'hA5, 8'h3C, 1'b1, 1'b1, "t4pre");

      for (int i = 0; i < 3; i++) cyc(8'hA5, 8'hFF, 1'b1, 1'b0, "t4hold");
      chk("t4.lit", 64'(Y), 64'h3C);

      async_reset("t5rst");
      cyc(8'h01, 8'hEE, 1'b0, 1'b1, "t5a");
      chk("t5a.lit", 64'(Y), 64'h01);

      for (int i = 0; i < 16; i++)
         cyc(8'h5A, 8'h5A, 1'($urandom_range(0, 1)), 1'b1, "t6");
      chk("t6.lit", 64'(Y), 64'h5A);

      for (int i = 0; i < 300; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         if ($urandom_range(0, 19) == 0) async_reset("rnd_rst");
         cyc(a, b, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
